// File: rtl/three_way_tcm_seq_if.sv
// Start/done handshake bundle for the sequential 3-way TCM multiplier.
// Master drives request and operands; slave returns status and product.
interface three_way_tcm_seq_if #(
  parameter int A_W = 192,
  parameter int B_W = 151
);
  logic               start;
  logic [A_W-1:0]     a;
  logic [B_W-1:0]     b;
  logic               busy;
  logic               done;
  logic [A_W+B_W-1:0] c;

  modport master (output start, a, b, input busy, done, c);
  modport slave  (input start, a, b, output busy, done, c);
endinterface

// File: rtl/three_way_tcm_seq.sv
// Bit-serial 3-way Toom-Cook-style carry-less multiplier, c = a*b over GF(2).
// Five limb-product groups accumulate in parallel, then recombine and drain.
module three_way_tcm_seq #(
  parameter int A_W  = 192,
  parameter int B_W  = 151,
  parameter int PIPE = 3
) (
  input logic clk,
  input logic rst,
  three_way_tcm_seq_if.slave bus
);
  localparam int MX  = (A_W > B_W) ? A_W : B_W;
  localparam int L   = (MX + 2) / 3;
  localparam int L3  = 3 * L;
  localparam int C_W = A_W + B_W;
  localparam int GW  = 2 * L - 1;
  localparam int KW  = $clog2(L + 1);
  localparam int DW  = (PIPE > 1) ? $clog2(PIPE) : 1;

  typedef enum logic [1:0] {
    IDLE, MUL, COMB, DRAIN
  } st_t;

  st_t st, nst;

  logic [L3-1:0]  sa;
  logic [L3-1:0]  rb;
  logic [GW-1:0]  h, g, f, e, d;
  logic [KW-1:0]  k;
  logic [DW-1:0]  dc;
  logic [C_W-1:0] rc, fv, c_q;
  logic           done_q;
  logic           busy, ld, acc, cmb, shf, fin;

  logic           a0, a1, a2;
  logic [L-1:0]   b0, b1, b2;

  // a limbs are shifted right each step, so bit 0 of each limb is ai[k]
  assign a0 = sa[0];
  assign a1 = sa[L];
  assign a2 = sa[2*L];
  assign b0 = rb[L-1:0];
  assign b1 = rb[2*L-1:L];
  assign b2 = rb[3*L-1:2*L];

  function automatic logic [GW-1:0] pp(
    input logic         s,
    input logic [L-1:0] bj,
    input logic [KW-1:0] sh
  );
    return s ? (GW'(bj) << sh) : '0;
  endfunction

  assign rc = C_W'(h)
            ^ (C_W'(g) << L)
            ^ (C_W'(f) << (2*L))
            ^ (C_W'(e) << (3*L))
            ^ (C_W'(d) << (4*L));

  // state register
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= nst;
  end

  // next-state logic
  always_comb begin
    nst = st;
    unique case (st)
      IDLE:  if (bus.start) nst = MUL;
      MUL:   if (k == KW'(L - 1)) nst = COMB;
      COMB:  nst = (PIPE == 0) ? IDLE : DRAIN;
      DRAIN: if (dc == DW'(PIPE - 1)) nst = IDLE;
      default: nst = IDLE;
    endcase
  end

  // per-state control strobes
  always_comb begin
    busy = 1'b0;
    ld   = 1'b0;
    acc  = 1'b0;
    cmb  = 1'b0;
    shf  = 1'b0;
    unique case (st)
      IDLE:  ld = bus.start;
      MUL:   begin busy = 1'b1; acc = 1'b1; end
      COMB:  begin busy = 1'b1; cmb = 1'b1; end
      DRAIN: begin busy = 1'b1; shf = 1'b1; end
      default: ;
    endcase
    fin = (PIPE == 0) ? cmb : (shf && dc == DW'(PIPE - 1));
  end

  // operand capture, shift-and-xor accumulation, drain count, result
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      rb     <= '0;
      h      <= '0;
      g      <= '0;
      f      <= '0;
      e      <= '0;
      d      <= '0;
      k      <= '0;
      dc     <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (ld) begin
        sa <= L3'(bus.a);
        rb <= L3'(bus.b);
        h  <= '0;
        g  <= '0;
        f  <= '0;
        e  <= '0;
        d  <= '0;
        k  <= '0;
      end
      if (acc) begin
        sa <= sa >> 1;
        h  <= h ^ pp(a0, b0, k);
        g  <= g ^ pp(a0, b1, k) ^ pp(a1, b0, k);
        f  <= f ^ pp(a0, b2, k) ^ pp(a1, b1, k)
                ^ pp(a2, b0, k);
        e  <= e ^ pp(a1, b2, k) ^ pp(a2, b1, k);
        d  <= d ^ pp(a2, b2, k);
        k  <= k + KW'(1);
      end
      if (cmb) dc <= '0;
      if (shf) dc <= dc + DW'(1);
      if (fin) c_q <= fv;
    end
  end

  if (PIPE == 0) begin : g_np
    assign fv = rc;
  end else begin : g_p
    logic [C_W-1:0] pl [PIPE];

    // stage 0 takes the recombined value, later stages shift while draining
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIPE; i++) pl[i] <= '0;
      end else if (cmb) begin
        pl[0] <= rc;
      end else if (shf) begin
        for (int i = 1; i < PIPE; i++) pl[i] <= pl[i-1];
      end
    end

    assign fv = pl[PIPE-1];
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.c    = c_q;
endmodule

// File: tb/tb_three_way_tcm_seq.sv
// Self-checking bench for three_way_tcm_seq in three parameter sets.
// Expected products come from a plain software carry-less multiply.
module tb_three_way_tcm_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_ass = 0;
  int n_fail = 0;

  three_way_tcm_seq_if #(.A_W(192), .B_W(151)) i0 ();
  three_way_tcm_seq_if #(.A_W(12),  .B_W(7))   i1 ();
  three_way_tcm_seq_if #(.A_W(100), .B_W(100)) i2 ();

  three_way_tcm_seq #(.A_W(192), .B_W(151), .PIPE(3)) u0 (
    .clk(clk), .rst(rst), .bus(i0)
  );
  three_way_tcm_seq #(.A_W(12), .B_W(7), .PIPE(0)) u1 (
    .clk(clk), .rst(rst), .bus(i1)
  );
  three_way_tcm_seq #(.A_W(100), .B_W(100), .PIPE(1)) u2 (
    .clk(clk), .rst(rst), .bus(i2)
  );

  function automatic logic [383:0] clmul(
    input logic [191:0] x,
    input logic [191:0] y
  );
    logic [383:0] r;
    r = '0;
    for (int i = 0; i < 192; i++)
      if (x[i]) r = r ^ ({192'b0, y} << i);
    return r;
  endfunction

  function automatic logic [191:0] rnd();
    return {$urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(
    input string tag,
    input logic [383:0] o,
    input logic [383:0] e
  );
    n_ass++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic go0(
    input  logic [191:0] x,
    input  logic [150:0] y,
    output int           lat,
    output int           bc,
    output logic [383:0] res,
    output int           td
  );
    i0.a = x; i0.b = y; i0.start = 1'b1;
    @(posedge clk); #1;
    i0.start = 1'b0;
    lat = 0; bc = 0;
    if (i0.busy) bc++;
    while (!i0.done && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      if (i0.busy) bc++;
    end
    res = 384'(i0.c);
    td = cyc;
  endtask

  task automatic go1(
    input  logic [11:0]  x,
    input  logic [6:0]   y,
    output int           lat,
    output logic [383:0] res,
    output int           td
  );
    i1.a = x; i1.b = y; i1.start = 1'b1;
    @(posedge clk); #1;
    i1.start = 1'b0;
    lat = 0;
    while (!i1.done && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    res = 384'(i1.c);
    td = cyc;
  endtask

  task automatic go2(
    input  logic [99:0]  x,
    input  logic [99:0]  y,
    output int           lat,
    output logic [383:0] res,
    output int           td
  );
    i2.a = x; i2.b = y; i2.start = 1'b1;
    @(posedge clk); #1;
    i2.start = 1'b0;
    lat = 0;
    while (!i2.done && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    res = 384'(i2.c);
    td = cyc;
  endtask

  initial begin
    logic [191:0] x, y, x2, y2;
    logic [383:0] res;
    int lat, bc, td, prev, dn, bz, c_at;
    logic [383:0] c_first;

    i0.start = 0; i0.a = '0; i0.b = '0;
    i1.start = 0; i1.a = '0; i1.b = '0;
    i2.start = 0; i2.a = '0; i2.b = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 384'(i0.busy), 384'(0));
    chk("rst_done", 384'(i0.done), 384'(0));
    chk("rst_c", 384'(i0.c), 384'(0));
    chk("rst_c1", 384'(i1.c), 384'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    go0(192'd1, 151'd1, lat, bc, res, td);
    chk("one_lat", 384'(lat), 384'(68));
    chk("one_busy_cycles", 384'(bc), 384'(68));
    chk("one_c", res, 384'(1));
    @(posedge clk); #1;
    chk("done_one_cycle", 384'(i0.done), 384'(0));
    chk("c_held", 384'(i0.c), 384'(1));

    x = 192'd1 << 191;
    y = 192'd1 << 150;
    go0(x, y[150:0], lat, bc, res, td);
    chk("top_c", res, clmul(x, y));
    chk("top_bit342", 384'(res[342]), 384'(0));
    chk("top_bit341", 384'(res[341]), 384'(1));
    @(posedge clk); #1;

    x = '1;
    go0(x, 151'd1, lat, bc, res, td);
    chk("ones_c", res, {192'b0, x});
    x = 192'hB;
    y = 192'h7;
    go0(x, y[150:0], lat, bc, res, td);
    chk("small_c", res, 384'h31);
    chk("small_space", 384'(lat), 384'(68));
    prev = td;

    for (int i = 0; i < 400; i++) begin
      x = rnd();
      y = rnd();
      y[191:151] = '0;
      go0(x, y[150:0], lat, bc, res, td);
      chk("r0_c", res, clmul(x, y));
      chk("r0_space", 384'(td - prev), 384'(69));
      prev = td;
    end
    @(posedge clk); #1;

    x = rnd();
    y = rnd();
    y[191:151] = '0;
    x2 = rnd();
    y2 = rnd();
    i0.a = x; i0.b = y[150:0]; i0.start = 1'b1;
    @(posedge clk); #1;
    i0.start = 1'b0;
    dn = 0;
    c_first = '0;
    c_at = 0;
    for (int i = 1; i <= 200; i++) begin
      if (i >= 10 && i < 16) begin
        i0.a = x2; i0.b = y2[150:0]; i0.start = 1'b1;
      end else begin
        i0.start = 1'b0;
      end
      @(posedge clk); #1;
      if (i0.done) begin
        dn++;
        if (dn == 1) begin
          c_first = 384'(i0.c);
          c_at = i;
        end
      end
    end
    i0.start = 1'b0;
    chk("ign_c", c_first, clmul(x, y));
    chk("ign_dones", 384'(dn), 384'(1));
    chk("ign_lat", 384'(c_at), 384'(68));

    x = rnd();
    y = rnd();
    y[191:151] = '0;
    i0.a = x; i0.b = y[150:0]; i0.start = 1'b1;
    @(posedge clk); #1;
    i0.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    bz = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (i0.done) dn++;
      if (i0.busy) bz++;
    end
    chk("rst_mid_dones", 384'(dn), 384'(0));
    chk("rst_mid_busy", 384'(bz), 384'(0));
    chk("rst_mid_c", 384'(i0.c), 384'(0));
    go0(x, y[150:0], lat, bc, res, td);
    chk("after_rst_c", res, clmul(x, y));
    chk("after_rst_lat", 384'(lat), 384'(68));
    @(posedge clk); #1;

    go1(12'hFFF, 7'h7F, lat, res, td);
    chk("r1_ones", res, clmul(192'hFFF, 192'h7F));
    chk("r1_lat", 384'(lat), 384'(5));
    prev = td;
    for (int i = 0; i < 1000; i++) begin
      x = rnd();
      y = rnd();
      x[191:12] = '0;
      y[191:7] = '0;
      go1(x[11:0], y[6:0], lat, res, td);
      chk("r1_c", res, clmul(x, y));
      chk("r1_space", 384'(td - prev), 384'(6));
      prev = td;
    end
    @(posedge clk); #1;

    go2(100'd1 << 99, 100'd1 << 99, lat, res, td);
    chk("r2_top", res, 384'(1) << 198);
    chk("r2_lat", 384'(lat), 384'(36));
    prev = td;
    for (int i = 0; i < 400; i++) begin
      x = rnd();
      y = rnd();
      x[191:100] = '0;
      y[191:100] = '0;
      go2(x[99:0], y[99:0], lat, res, td);
      chk("r2_c", res, clmul(x, y));
      chk("r2_space", 384'(td - prev), 384'(37));
      prev = td;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_ass, n_fail);
    $finish;
  end
endmodule
